// File: rtl/gerador_echo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gerador_echo                                           |
// | Description : Ultrasonic-sensor echo generator. Answers a valid      |
// |               trigger pulse with an echo pulse whose width encodes   |
// |               a 3-digit BCD distance (TICKS_CM cycles per cm).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gerador_echo #(
  parameter int TRIG_MIN     = 500,
  parameter int BURST_CICLOS = 10000,
  parameter int TICKS_CM     = 2941,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CM   = 646
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic [11:0] distancia,
  output logic        echo,
  output logic        ocupado,
  output logic        pronto,
  output logic [2:0]  db_estado
);

  // ------------------------------------------------------------------
  // Counter widths. Degenerate 1-cycle parameters still get 1-bit
  // counters; the cm counter is at least 10 bits so that the binary
  // value of any 3-digit BCD number (up to 999) fits.
  // ------------------------------------------------------------------
  localparam int c_TRIG_W  = $clog2(TRIG_MIN + 1);
  localparam int c_BURST_W = (BURST_CICLOS > 1) ? $clog2(BURST_CICLOS) : 1;
  localparam int c_TICK_W  = (TICKS_CM > 1) ? $clog2(TICKS_CM) : 1;
  localparam int c_CM_MAXV = (MAX_CM > TIMEOUT_CM) ? MAX_CM : TIMEOUT_CM;
  localparam int c_CM_RAW  = $clog2(c_CM_MAXV + 1);
  localparam int c_CM_W    = (c_CM_RAW > 10) ? c_CM_RAW : 10;

  localparam logic [c_TRIG_W-1:0]  c_TRIG_MIN   = c_TRIG_W'(TRIG_MIN);
  localparam logic [c_TRIG_W-1:0]  c_TRIG_ONE   = c_TRIG_W'(1);
  localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(BURST_CICLOS - 1);
  localparam logic [c_BURST_W-1:0] c_BURST_ONE  = c_BURST_W'(1);
  localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(TICKS_CM - 1);
  localparam logic [c_TICK_W-1:0]  c_TICK_ONE   = c_TICK_W'(1);
  localparam logic [c_CM_W-1:0]    c_MAX_CM     = c_CM_W'(MAX_CM);
  localparam logic [c_CM_W-1:0]    c_TIMEOUT_CM = c_CM_W'(TIMEOUT_CM);
  localparam logic [c_CM_W-1:0]    c_CM_ONE     = c_CM_W'(1);
  localparam logic [c_CM_W-1:0]    c_CM_TEN     = c_CM_W'(10);
  localparam logic [c_CM_W-1:0]    c_CM_HUNDRED = c_CM_W'(100);
  localparam logic [3:0]           c_DIGIT_MAX  = 4'd9;

  // ------------------------------------------------------------------
  // State encoding: the codes are visible on db_estado, so they are
  // fixed explicitly rather than left to the tool.
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_INICIAL      = 3'b000,
    S_MEDE_TRIGGER = 3'b001,
    S_BURST        = 3'b010,
    S_ECHO_ALTO    = 3'b011,
    S_FIM          = 3'b100
  } t_estado;

  t_estado r_state;
  t_estado w_next_state;

  logic [c_TRIG_W-1:0]  r_trig_cnt;
  logic [c_BURST_W-1:0] r_burst_cnt;
  logic [c_TICK_W-1:0]  r_tick_cnt;
  logic [c_CM_W-1:0]    r_cm_cnt;
  logic [11:0]          r_dist;

  logic [c_CM_W-1:0] w_hund;
  logic [c_CM_W-1:0] w_tens;
  logic [c_CM_W-1:0] w_unit;
  logic [c_CM_W-1:0] w_bin;
  logic [c_CM_W-1:0] w_n;
  logic [c_CM_W-1:0] w_n_last;
  logic              w_digits_ok;
  logic              w_n_zero;
  logic              w_trig_ok;
  logic              w_burst_done;
  logic              w_tick_wrap;
  logic              w_echo_done;

  // ------------------------------------------------------------------
  // Echo width N in cm units, derived from the latched distance only,
  // so later changes on distancia cannot disturb an echo in progress.
  // Any non-decimal digit or a value above MAX_CM reports a timeout.
  // ------------------------------------------------------------------
  assign w_hund      = c_CM_W'(r_dist[11:8]);
  assign w_tens      = c_CM_W'(r_dist[7:4]);
  assign w_unit      = c_CM_W'(r_dist[3:0]);
  assign w_bin       = (w_hund * c_CM_HUNDRED) + (w_tens * c_CM_TEN) + w_unit;
  assign w_digits_ok = (r_dist[11:8] <= c_DIGIT_MAX) &&
                       (r_dist[7:4]  <= c_DIGIT_MAX) &&
                       (r_dist[3:0]  <= c_DIGIT_MAX);
  assign w_n         = (w_digits_ok && (w_bin <= c_MAX_CM)) ? w_bin : c_TIMEOUT_CM;
  assign w_n_zero    = (w_n == '0);
  assign w_n_last    = w_n - c_CM_ONE;

  // Status flags used by both the state machine and the counters.
  assign w_trig_ok    = (r_trig_cnt >= c_TRIG_MIN);
  assign w_burst_done = (r_burst_cnt == c_BURST_LAST);
  assign w_tick_wrap  = (r_tick_cnt == c_TICK_LAST);
  assign w_echo_done  = w_tick_wrap && (r_cm_cnt == w_n_last);

  // State register; reset forces the idle state at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INICIAL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision for the trigger/burst/echo sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INICIAL: begin
        if (trigger) begin
          w_next_state = S_MEDE_TRIGGER;
        end
      end
      S_MEDE_TRIGGER: begin
        if (!trigger) begin
          w_next_state = w_trig_ok ? S_BURST : S_INICIAL;
        end
      end
      S_BURST: begin
        if (w_burst_done) begin
          w_next_state = w_n_zero ? S_FIM : S_ECHO_ALTO;
        end
      end
      S_ECHO_ALTO: begin
        if (w_echo_done) begin
          w_next_state = S_FIM;
        end
      end
      S_FIM: begin
        w_next_state = S_INICIAL;
      end
      default: begin
        w_next_state = S_INICIAL;
      end
    endcase
  end

  // Trigger-width measurement, distance latch and the burst/echo timers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_trig_cnt  <= '0;
      r_burst_cnt <= '0;
      r_tick_cnt  <= '0;
      r_cm_cnt    <= '0;
      r_dist      <= '0;
    end else begin
      case (r_state)
        S_INICIAL: begin
          if (trigger) begin
            r_trig_cnt <= c_TRIG_ONE;
          end
        end
        S_MEDE_TRIGGER: begin
          if (trigger) begin
            // Saturate so an arbitrarily long trigger cannot wrap back
            // below the validity threshold.
            if (r_trig_cnt < c_TRIG_MIN) begin
              r_trig_cnt <= r_trig_cnt + c_TRIG_ONE;
            end
          end else if (w_trig_ok) begin
            r_dist      <= distancia;
            r_burst_cnt <= '0;
          end
        end
        S_BURST: begin
          if (w_burst_done) begin
            r_tick_cnt <= '0;
            r_cm_cnt   <= '0;
          end else begin
            r_burst_cnt <= r_burst_cnt + c_BURST_ONE;
          end
        end
        S_ECHO_ALTO: begin
          if (w_tick_wrap) begin
            r_tick_cnt <= '0;
            r_cm_cnt   <= r_cm_cnt + c_CM_ONE;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
          end
        end
        default: begin
          // fim and unused codes hold every counter.
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  assign echo      = (r_state == S_ECHO_ALTO);
  assign ocupado   = (r_state == S_BURST) || (r_state == S_ECHO_ALTO) || (r_state == S_FIM);
  assign pronto    = (r_state == S_FIM);
  assign db_estado = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gerador_echo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gerador_echo                                        |
// | Description : Self-checking bench for gerador_echo. Stimulus pushes  |
// |               expected echo widths into a queue; an independent      |
// |               monitor times each response and compares on pronto.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gerador_echo;

  localparam int TRIG_MIN     = 5;
  localparam int BURST_CICLOS = 4;
  localparam int TICKS_CM     = 3;
  localparam int MAX_CM       = 400;
  localparam int TIMEOUT_CM   = 646;

  logic        clock;
  logic        reset;
  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        ocupado;
  logic        pronto;
  logic [2:0]  db_estado;

  int n_tests;
  int n_fail;

  // Expected echo widths in clock cycles, one per accepted trigger.
  int exp_q[$];

  gerador_echo #(
    .TRIG_MIN    (TRIG_MIN),
    .BURST_CICLOS(BURST_CICLOS),
    .TICKS_CM    (TICKS_CM),
    .MAX_CM      (MAX_CM),
    .TIMEOUT_CM  (TIMEOUT_CM)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .distancia(distancia),
    .echo     (echo),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: distance in cm from the BCD word, timeout for bad input.
  function automatic int model_cm(input logic [11:0] d);
    int h;
    int t;
    int u;
    int v;
    h = int'(d[11:8]);
    t = int'(d[7:4]);
    u = int'(d[3:0]);
    if (h > 9 || t > 9 || u > 9) return TIMEOUT_CM;
    v = h * 100 + t * 10 + u;
    if (v > MAX_CM) return TIMEOUT_CM;
    return v;
  endfunction

  // ------------------------------------------------------------------
  // Monitor: timestamps ocupado rise, echo rise/fall and pronto, then
  // scores the finished transaction against the head of the queue.
  // ------------------------------------------------------------------
  int  cyc;
  int  t_ocu;
  int  t_rise;
  int  t_fall;
  bit  active;
  bit  seen_echo;
  bit  prev_echo;
  bit  prev_pronto;
  int  exp_w;

  always @(negedge clock) begin
    if (!reset) begin
      active      = 1'b0;
      seen_echo   = 1'b0;
      prev_echo   = 1'b0;
      prev_pronto = 1'b0;
    end else begin
      cyc++;
      if (ocupado && !active) begin
        active    = 1'b1;
        t_ocu     = cyc;
        seen_echo = 1'b0;
      end
      if (echo && !ocupado) check("echo_without_ocupado", 1, 0);
      if (echo && !prev_echo) begin
        t_rise    = cyc;
        seen_echo = 1'b1;
      end
      if (!echo && prev_echo) t_fall = cyc;
      if (prev_pronto) check("ocupado_after_pronto", int'(ocupado), 0);
      if (pronto) begin
        if (prev_pronto) begin
          check("pronto_width", 2, 1);
        end else if (exp_q.size() == 0) begin
          check("unexpected_pronto", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("pronto_ocupado", int'(ocupado), 1);
          if (exp_w == 0) begin
            check("zero_echo_seen", int'(seen_echo), 0);
            check("zero_pronto_delay", cyc - t_ocu, BURST_CICLOS);
          end else begin
            check("echo_seen", int'(seen_echo), 1);
            check("echo_rise_delay", t_rise - t_ocu, BURST_CICLOS);
            check("echo_width", t_fall - t_rise, exp_w);
            check("pronto_after_echo", cyc - t_fall, 0);
          end
        end
        active = 1'b0;
      end
      prev_echo   = echo;
      prev_pronto = pronto;
    end
  end

  // Drive one trigger of 'hi' sampled-high cycles carrying distance d;
  // distancia is scrambled right after the latch edge.
  task automatic do_trigger(input logic [11:0] d, input int hi);
    @(negedge clock);
    distancia = d;
    trigger   = 1'b1;
    repeat (hi) @(negedge clock);
    trigger = 1'b0;
    if (hi >= TRIG_MIN) exp_q.push_back(model_cm(d) * TICKS_CM);
    @(negedge clock);
    distancia = 12'($urandom);
  endtask

  // Wait until every queued response has been scored and the DUT is idle.
  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0 && !ocupado) break;
    end
    if (k >= budget) begin
      check("response_timeout", k, budget - 1);
      exp_q.delete();
    end
  endtask

  task automatic wait_echo(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clock);
      #1;
      if (echo) break;
    end
    if (k >= budget) check("echo_rise_timeout", 0, 1);
  endtask

  initial begin
    logic [11:0] d;
    int          hi;
    int          seen_p;

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b0;
    trigger   = 1'b0;
    distancia = 12'h000;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_echo", int'(echo), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_estado", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b1;

    // Nominal: 12 cm -> 36 cycles.
    do_trigger(12'h012, TRIG_MIN);
    wait_done(200);

    // Short trigger is ignored.
    do_trigger(12'h012, TRIG_MIN - 1);
    seen_p = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (ocupado || echo || pronto) seen_p++;
    end
    check("short_trig_activity", seen_p, 0);
    check("short_trig_estado", int'(db_estado), 0);

    // Limits, invalid digit and zero distance.
    do_trigger(12'h400, TRIG_MIN);
    wait_done(1400);
    do_trigger(12'h401, TRIG_MIN);
    wait_done(2100);
    do_trigger(12'h0A3, TRIG_MIN + 3);
    wait_done(2100);
    do_trigger(12'h000, TRIG_MIN);
    wait_done(50);

    // Randomized distances and trigger widths around the threshold.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) d = 12'($urandom);
      else d = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      hi = $urandom_range(TRIG_MIN - 2, TRIG_MIN + 4);
      do_trigger(d, hi);
      wait_done(2100);
    end

    // Inputs ignored while busy: new distance and a long trigger mid-echo.
    do_trigger(12'h012, TRIG_MIN);
    wait_echo(50);
    @(negedge clock);
    distancia = 12'h399;
    trigger   = 1'b1;
    repeat (TRIG_MIN + 1) @(negedge clock);
    trigger = 1'b0;
    wait_done(200);

    // Reset mid-echo: echo drops at once and no pronto follows.
    do_trigger(12'h050, TRIG_MIN);
    wait_echo(50);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_echo", int'(echo), 0);
    check("midrst_estado", int'(db_estado), 0);
    check("midrst_ocupado", int'(ocupado), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    seen_p = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (pronto || ocupado) seen_p++;
    end
    check("midrst_no_pronto", seen_p, 0);

    // Recovery after reset.
    do_trigger(12'h007, TRIG_MIN);
    wait_done(100);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
